// File: rtl/cache_nway.sv
// N-way set-associative write-back/write-allocate cache, tree PLRU, perf counters under CACHE_PERF_CNT_EN.
// Latency: hit responds one cycle after the request is seen; miss adds optional writeback plus fill.
// Backpressure: CPU holds its request until mem_resp; pmem strobes are held until pmem_resp.
module cache_nway #(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3,
    parameter int NUM_WAYS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                mem_address,
    input  logic                       mem_read,
    input  logic                       mem_write,
    input  logic [(1<<S_OFFSET)-1:0]   mem_byte_enable256,
    input  logic [(8<<S_OFFSET)-1:0]   mem_wdata256,
    output logic [(8<<S_OFFSET)-1:0]   mem_rdata256,
    output logic                       mem_resp,
    output logic [31:0]                pmem_address,
    output logic                       pmem_read,
    output logic                       pmem_write,
    output logic [(8<<S_OFFSET)-1:0]   pmem_wdata,
    input  logic [(8<<S_OFFSET)-1:0]   pmem_rdata,
    input  logic                       pmem_resp,
    output logic [31:0]                hit_count,
    output logic [31:0]                miss_count,
    output logic [31:0]                wb_count
);
    localparam int S_TAG  = 32 - S_OFFSET - S_INDEX;
    localparam int SETS   = 1 << S_INDEX;
    localparam int LINE_W = 8 << S_OFFSET;
    localparam int BYTES  = 1 << S_OFFSET;
    localparam int WAY_W  = $clog2(NUM_WAYS);

    typedef enum logic [1:0] {IDLE, TAG_CHECK, WRITEBACK, FILL} state_t;
    state_t state, state_nx;

    logic [S_TAG-1:0]    tag_arr   [SETS][NUM_WAYS];
    logic [LINE_W-1:0]   data_arr  [SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_arr [SETS];
    logic [NUM_WAYS-1:0] dirty_arr [SETS];
    // Heap-ordered tree: node n has children 2n and 2n+1; leaves n-NUM_WAYS are ways.
    logic [NUM_WAYS-1:1] plru_arr  [SETS];

    logic [S_INDEX-1:0]  req_idx;
    logic [S_TAG-1:0]    req_tag;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic [LINE_W-1:0]   hit_line;
    logic [LINE_W-1:0]   merged;
    logic [NUM_WAYS-1:1] cur_plru;
    logic [NUM_WAYS-1:1] plru_upd;
    logic                invalid_found;
    logic [WAY_W-1:0]    inv_way;
    logic [WAY_W-1:0]    plru_way;
    logic [WAY_W-1:0]    victim_sel;
    logic [WAY_W-1:0]    victim_q;
    logic                victim_dirty;
    logic                nbit;
    logic                ubit;
    int                  vnode;
    int                  unode;
    logic                unused_addr;

    assign req_idx     = mem_address[S_OFFSET +: S_INDEX];
    assign req_tag     = mem_address[31 -: S_TAG];
    assign cur_plru    = plru_arr[req_idx];
    assign hit_line    = data_arr[req_idx][hit_way];
    assign unused_addr = ^mem_address[S_OFFSET-1:0];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_arr[req_idx][w] && tag_arr[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Invalid ways win over PLRU; descending scan leaves the lowest index.
    always_comb begin
        invalid_found = 1'b0;
        inv_way       = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_arr[req_idx][w]) begin
                invalid_found = 1'b1;
                inv_way       = WAY_W'(w);
            end
        end
        vnode = 1;
        nbit  = 1'b0;
        for (int l = 0; l < WAY_W; l++) begin
            nbit = 1'b0;
            for (int n = 1; n < NUM_WAYS; n++) begin
                if (vnode == n) nbit = cur_plru[n];
            end
            vnode = 2 * vnode + (nbit ? 1 : 0);
        end
        plru_way     = WAY_W'(vnode - NUM_WAYS);
        victim_sel   = invalid_found ? inv_way : plru_way;
        victim_dirty = valid_arr[req_idx][victim_sel] && dirty_arr[req_idx][victim_sel];
    end

    always_comb begin
        plru_upd = cur_plru;
        unode    = 1;
        ubit     = 1'b0;
        for (int l = 0; l < WAY_W; l++) begin
            ubit = hit_way[WAY_W-1-l];
            for (int n = 1; n < NUM_WAYS; n++) begin
                if (unode == n) plru_upd[n] = ~ubit;
            end
            unode = 2 * unode + (ubit ? 1 : 0);
        end
    end

    always_comb begin
        merged = hit_line;
        for (int b = 0; b < BYTES; b++) begin
            if (mem_byte_enable256[b]) merged[8*b +: 8] = mem_wdata256[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (mem_read || mem_write) state_nx = TAG_CHECK;
            TAG_CHECK: begin
                if (hit)               state_nx = IDLE;
                else if (victim_dirty) state_nx = WRITEBACK;
                else                   state_nx = FILL;
            end
            WRITEBACK: if (pmem_resp) state_nx = FILL;
            FILL:      if (pmem_resp) state_nx = TAG_CHECK;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_resp     = (state == TAG_CHECK) && hit;
        mem_rdata256 = mem_resp ? hit_line : '0;
        pmem_write   = (state == WRITEBACK);
        pmem_read    = (state == FILL);
        pmem_wdata   = data_arr[req_idx][victim_q];
        case (state)
            WRITEBACK: pmem_address = {tag_arr[req_idx][victim_q], req_idx, {S_OFFSET{1'b0}}};
            FILL:      pmem_address = {req_tag, req_idx, {S_OFFSET{1'b0}}};
            default:   pmem_address = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_arr[s] <= '0;
                dirty_arr[s] <= '0;
                plru_arr[s]  <= '0;
            end
            victim_q <= '0;
        end else begin
            if (state == TAG_CHECK) begin
                if (hit) begin
                    plru_arr[req_idx] <= plru_upd;
                    if (mem_write) dirty_arr[req_idx][hit_way] <= 1'b1;
                end else begin
                    victim_q <= victim_sel;
                end
            end
            if (state == FILL && pmem_resp) begin
                valid_arr[req_idx][victim_q] <= 1'b1;
                dirty_arr[req_idx][victim_q] <= 1'b0;
            end
        end
    end

    // Payload arrays carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == TAG_CHECK && hit && mem_write)
                data_arr[req_idx][hit_way] <= merged;
            if (state == FILL && pmem_resp) begin
                data_arr[req_idx][victim_q] <= pmem_rdata;
                tag_arr[req_idx][victim_q]  <= req_tag;
            end
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic        filled_q;
    logic [31:0] hit_q;
    logic [31:0] miss_q;
    logic [31:0] wb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            filled_q <= 1'b0;
            hit_q    <= '0;
            miss_q   <= '0;
            wb_q     <= '0;
        end else begin
            if (state == FILL && pmem_resp) filled_q <= 1'b1;
            else if (mem_resp)              filled_q <= 1'b0;
            if (state == TAG_CHECK && hit && !filled_q && hit_q != '1) hit_q <= hit_q + 32'd1;
            if (state == TAG_CHECK && !hit && miss_q != '1)            miss_q <= miss_q + 32'd1;
            if (state == WRITEBACK && pmem_resp && wb_q != '1)         wb_q <= wb_q + 32'd1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
    assign wb_count   = wb_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
    assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_cache_nway.sv
// Bench for cache_nway: directed scenarios then random traffic against a behavioural cache model.
module tb_cache_nway;
    localparam int SETS = 8;
    localparam int WAYS = 4;
    localparam int LW   = 256;
    localparam int TAGW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   mem_address;
    logic          mem_read;
    logic          mem_write;
    logic [31:0]   mem_byte_enable256;
    logic [LW-1:0] mem_wdata256;
    logic [LW-1:0] mem_rdata256;
    logic          mem_resp;
    logic [31:0]   pmem_address;
    logic          pmem_read;
    logic          pmem_write;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;
    logic [31:0]   hit_count;
    logic [31:0]   miss_count;
    logic [31:0]   wb_count;

    always #5 clk = ~clk;

    cache_nway dut (
        .clk(clk), .rst(rst),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable256(mem_byte_enable256), .mem_wdata256(mem_wdata256),
        .mem_rdata256(mem_rdata256), .mem_resp(mem_resp),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: per-way state plus a per-set tree of "victim in upper half" flags.
    bit            m_valid [SETS][WAYS];
    bit            m_dirty [SETS][WAYS];
    logic [TAGW-1:0] m_tag [SETS][WAYS];
    logic [LW-1:0] m_data  [SETS][WAYS];
    bit            m_tree  [SETS][WAYS];
    logic [LW-1:0] pmem_mem [logic [31:0]];
    int exp_hits = 0, exp_misses = 0, exp_wbs = 0;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom();
        return l;
    endfunction

    function automatic logic [LW-1:0] pmem_get(input logic [31:0] a);
        if (!pmem_mem.exists(a)) pmem_mem[a] = rand_line();
        return pmem_mem[a];
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
                m_tree[s][w]  = 0;
            end
        exp_hits = 0; exp_misses = 0; exp_wbs = 0;
    endtask

    function automatic int pick_victim(input int s);
        int lo, hi, node, mid;
        for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
        lo = 0; hi = WAYS; node = 1;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (m_tree[s][node]) begin lo = mid; node = 2 * node + 1; end
            else                 begin hi = mid; node = 2 * node;     end
        end
        return lo;
    endfunction

    task automatic touch(input int s, input int w);
        int lo, hi, node, mid;
        lo = 0; hi = WAYS; node = 1;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (w < mid) begin m_tree[s][node] = 1; hi = mid; node = 2 * node;     end
            else         begin m_tree[s][node] = 0; lo = mid; node = 2 * node + 1; end
        end
    endtask

    task automatic chk_counters(input string tag);
`ifdef CACHE_PERF_CNT_EN
        chk({tag, "_hits"},   hit_count,  exp_hits);
        chk({tag, "_misses"}, miss_count, exp_misses);
        chk({tag, "_wbs"},    wb_count,   exp_wbs);
`else
        chk({tag, "_hits"},   hit_count,  0);
        chk({tag, "_misses"}, miss_count, 0);
        chk({tag, "_wbs"},    wb_count,   0);
`endif
    endtask

    task automatic do_req(input logic [31:0] addr, input bit rd, input bit wr,
                          input logic [31:0] be, input logic [LW-1:0] wd);
        int s, w, cyc, wb_dly, fill_dly;
        logic [TAGW-1:0] tag;
        logic [31:0] base, wb_addr, got_wb_addr, got_fill_addr;
        logic [LW-1:0] wb_data, got_wb_data, exp_rdata, got_rdata;
        bit exp_miss, exp_wb, got, wb_seen, fill_seen, both_high, miss_idle_ok;

        s    = int'(addr[7:5]);
        tag  = addr[31:8];
        base = {addr[31:5], 5'b0};
        w = -1;
        for (int i = 0; i < WAYS; i++) if (m_valid[s][i] && m_tag[s][i] == tag) w = i;
        exp_miss = (w < 0);
        exp_wb   = 0;
        wb_addr  = '0;
        wb_data  = '0;
        if (exp_miss) begin
            w = pick_victim(s);
            exp_misses++;
            if (m_valid[s][w] && m_dirty[s][w]) begin
                exp_wb  = 1;
                wb_addr = {m_tag[s][w], addr[7:5], 5'b0};
                wb_data = m_data[s][w];
                pmem_mem[wb_addr] = wb_data;
                exp_wbs++;
            end
            m_data[s][w]  = pmem_get(base);
            m_tag[s][w]   = tag;
            m_valid[s][w] = 1;
            m_dirty[s][w] = 0;
        end else begin
            exp_hits++;
        end
        exp_rdata = m_data[s][w];
        if (wr) begin
            for (int b = 0; b < 32; b++) if (be[b]) m_data[s][w][8*b +: 8] = wd[8*b +: 8];
            m_dirty[s][w] = 1;
        end
        touch(s, w);

        @(negedge clk);
        mem_address = addr; mem_read = rd; mem_write = wr;
        mem_byte_enable256 = be; mem_wdata256 = wd;
        cyc = 0; got = 0; wb_seen = 0; fill_seen = 0; both_high = 0; miss_idle_ok = 1;
        wb_dly = 0; fill_dly = 0;
        got_wb_addr = '0; got_wb_data = '0; got_fill_addr = '0; got_rdata = '0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            pmem_resp = 0;
            if (pmem_read && pmem_write) both_high = 1;
            if (cyc == 1 && exp_miss && (mem_resp !== 1'b0 || mem_rdata256 !== '0)) miss_idle_ok = 0;
            if (mem_resp) begin
                got = 1;
                got_rdata = mem_rdata256;
            end else if (pmem_write) begin
                if (!wb_seen) begin
                    wb_seen = 1; got_wb_addr = pmem_address; got_wb_data = pmem_wdata;
                    wb_dly = $urandom_range(0, 3);
                end
                if (wb_dly == 0) pmem_resp = 1;
                else wb_dly--;
            end else if (pmem_read) begin
                if (!fill_seen) begin
                    fill_seen = 1; got_fill_addr = pmem_address;
                    fill_dly = $urandom_range(0, 3);
                end
                if (fill_dly == 0) begin
                    pmem_rdata = pmem_get(pmem_address);
                    pmem_resp = 1;
                end else fill_dly--;
            end
        end
        chk("resp_seen", got, 1);
        chk("rdata", got_rdata, exp_rdata);
        chk("fill_occurred", fill_seen, exp_miss);
        chk("wb_occurred", wb_seen, exp_wb);
        chk("pmem_exclusive", both_high, 0);
        if (exp_miss) begin
            chk("fill_addr", got_fill_addr, base);
            chk("miss_no_resp_in_tag_check", miss_idle_ok, 1);
        end else begin
            chk("hit_latency", cyc, 1);
        end
        if (exp_wb) begin
            chk("wb_addr", got_wb_addr, wb_addr);
            chk("wb_data", got_wb_data, wb_data);
        end
        @(posedge clk);
        #1;
        mem_read = 0; mem_write = 0;
    endtask

    initial begin
        logic [31:0] ff_be;
        logic [31:0] a;
        int rw;
        bit seen;

        rst = 1; mem_address = '0; mem_read = 0; mem_write = 0;
        mem_byte_enable256 = '0; mem_wdata256 = '0; pmem_rdata = '0; pmem_resp = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_mem_resp", mem_resp, 0);
        chk("rst_rdata", mem_rdata256, 0);
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_pmem_addr", pmem_address, 0);
        chk_counters("rst");
        rst = 0;

        ff_be = 32'h0000_000F;
        do_req(32'h040, 1, 0, '0, '0);
        do_req(32'h040, 1, 0, '0, '0);
        do_req(32'h040, 0, 1, ff_be, {LW{1'b1}});
        chk_counters("after_s1_s2");
        do_req(32'h040, 1, 0, '0, '0);

        do_req(32'h140, 1, 0, '0, '0);
        do_req(32'h240, 1, 0, '0, '0);
        do_req(32'h340, 1, 0, '0, '0);
        do_req(32'h040, 1, 0, '0, '0);
        do_req(32'h140, 1, 0, '0, '0);
        do_req(32'h240, 0, 1, 32'hF0F0_0001, rand_line());
        do_req(32'h340, 1, 0, '0, '0);
        do_req(32'h040, 1, 0, '0, '0);
        do_req(32'h440, 1, 0, '0, '0);
        do_req(32'h140, 1, 0, '0, '0);
        do_req(32'h240, 1, 1, 32'h8000_0003, rand_line());
        chk_counters("after_plru");

        // Reset during a fill of an untouched set.
        @(negedge clk);
        mem_address = 32'h0A0; mem_read = 1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (pmem_read) seen = 1;
        end
        chk("rst_fill_started", seen, 1);
        rst = 1; mem_read = 0;
        @(negedge clk);
        chk("midfill_pmem_read_drop", pmem_read, 0);
        chk("midfill_pmem_addr", pmem_address, 0);
        rst = 0; pmem_resp = 1; pmem_rdata = rand_line();
        @(negedge clk);
        pmem_resp = 0;
        chk("late_resp_mem_resp", mem_resp, 0);
        chk("late_resp_pmem_read", pmem_read, 0);
        chk("late_resp_pmem_write", pmem_write, 0);
        @(negedge clk);
        chk("idle_stays_quiet", pmem_read | pmem_write | mem_resp, 0);
        model_reset();
        chk_counters("after_midfill_rst");
        do_req(32'h040, 1, 0, '0, '0);

        for (int n = 0; n < 250; n++) begin
            a = (32'($urandom_range(0, 7)) << 8) | (32'($urandom_range(0, 7)) << 5)
                | 32'($urandom_range(0, 31));
            rw = $urandom_range(0, 3);
            do_req(a, rw != 1, rw == 1 || rw == 2, $urandom(), rand_line());
        end
        chk_counters("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
